// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: ADD/XOR/OR/AND in 1 cycle, shifts iterate 1 bit/cycle (shamt+1 cycles to out_valid).
// Backpressure: accepts only in IDLE and holds result/out_valid in DONE until out_ready; flush kills the op.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_ctrl,
  input  logic            arith,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic left;
    logic arith;
  } shop_t;

  state_t               state, state_nxt;
  shop_t                shop, shop_nxt;
  logic [XLEN-1:0]      result_nxt;
  logic [XLEN-1:0]      acc, acc_nxt;
  logic [SHAMT_W-1:0]   cnt, cnt_nxt;

  logic                 is_shift;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      alu_res;
  logic [XLEN-1:0]      acc_shifted;

  assign is_shift  = (alu_ctrl[2:1] == 2'b10);
  assign shamt     = op_b[SHAMT_W-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // 11x falls back to ADD; shift codes never use this path.
  always_comb begin
    alu_res = op_a + op_b;
    case (alu_ctrl)
      3'b001:  alu_res = op_a ^ op_b;
      3'b010:  alu_res = op_a | op_b;
      3'b011:  alu_res = op_a & op_b;
      default: alu_res = op_a + op_b;
    endcase
  end

  always_comb begin
    if (shop.left)
      acc_shifted = {acc[XLEN-2:0], 1'b0};
    else
      acc_shifted = {shop.arith & acc[XLEN-1], acc[XLEN-1:1]};
  end

  always_comb begin
    state_nxt  = state;
    shop_nxt   = shop;
    result_nxt = result;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          shop_nxt = '{left: ~alu_ctrl[0], arith: arith};
          if (!is_shift) begin
            result_nxt = alu_res;
            state_nxt  = DONE;
          end else if (shamt == '0) begin
            result_nxt = op_a;
            state_nxt  = DONE;
          end else begin
            acc_nxt   = op_a;
            cnt_nxt   = shamt;
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          acc_nxt = acc_shifted;
          cnt_nxt = cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result_nxt = acc_shifted;
            state_nxt  = DONE;
          end
        end
      end
      DONE: begin
        // flush wins over out_ready, but both simply drop back to IDLE
        if (flush || out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shop   <= '0;
      result <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      shop   <= shop_nxt;
      result <= result_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, latency, backpressure, flush and reset.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_ctrl;
  logic        arith;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .arith     (arith),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Offer one op from IDLE, scramble inputs after accept, wait for the result and take it.
  task automatic issue(input logic [2:0] c, input logic ar, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    alu_ctrl = c; arith = ar; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_ctrl = ~c; arith = ~ar; op_a = ~a; op_b = ~b;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    res = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 00000000", result); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_logic_ops;
    logic [2:0]  c   [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
    logic [31:0] a   [5] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h00FF_00F0, 32'hF0F0_F0F0, 32'h0000_0010};
    logic [31:0] b   [5] = '{32'h0000_0002, 32'hFFFF_0000, 32'h0F0F_0000, 32'hFF00_FF00, 32'hFFFF_FFFF};
    logic [31:0] exp [5] = '{32'h0000_0001, 32'hEDCB_5678, 32'h0FFF_00F0, 32'hF000_F000, 32'h0000_000F};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 5; i++) begin
      issue(c[i], 1'b0, a[i], b[i], lat, res);
      vectors++; if (res !== exp[i]) begin miscompares++; $display("FAIL logic_res[%0d] got %h want %h", i, res, exp[i]); end
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL logic_lat[%0d] got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_default_add;
    int lat;
    logic [31:0] res;
    issue(3'b110, 1'b1, 32'd5, 32'd7, lat, res);
    vectors++; if (res !== 32'd12) begin miscompares++; $display("FAIL default_add got %h want 0000000c", res); end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL default_add_lat got %0d want 1", lat); end
  endtask

  task automatic test_shifts;
    logic [2:0]  c   [7] = '{3'b101, 3'b101, 3'b100, 3'b100, 3'b101, 3'b101, 3'b100};
    logic        ar  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] a   [7] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'hDEAD_BEEF,
                             32'h8000_00F0, 32'h7000_0000, 32'h8000_0001};
    logic [31:0] b   [7] = '{32'd31, 32'd31, 32'hFFFF_FFE4, 32'hFFFF_FFE0, 32'd4, 32'd4, 32'd1};
    logic [31:0] exp [7] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0010, 32'hDEAD_BEEF,
                             32'hF800_000F, 32'h0700_0000, 32'h0000_0002};
    int          el  [7] = '{32, 32, 5, 1, 5, 5, 2};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 7; i++) begin
      issue(c[i], ar[i], a[i], b[i], lat, res);
      vectors++; if (res !== exp[i]) begin miscompares++; $display("FAIL shift_res[%0d] got %h want %h", i, res, exp[i]); end
      vectors++; if (lat !== el[i]) begin miscompares++; $display("FAIL shift_lat[%0d] got %0d want %0d", i, lat, el[i]); end
    end
  endtask

  // XOR held under backpressure while a second op waits; it must go in the cycle after the handshake.
  task automatic test_back_to_back;
    alu_ctrl = 3'b001; arith = 1'b0; op_a = 32'hF0F0_F0F0; op_b = 32'hFF00_FF00; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_ctrl = 3'b000; op_a = 32'd3; op_b = 32'd4;
    for (int i = 0; i < 10; i++) begin
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      vectors++; if (result !== 32'h0FF0_0FF0) begin miscompares++; $display("FAIL bp_result[%0d] got %h want 0ff00ff0", i, result); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_gap_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_second_valid got %b want 1", out_valid); end
    vectors++; if (result !== 32'd7) begin miscompares++; $display("FAIL b2b_second_result got %h want 00000007", result); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    bit seen;
    // flush on shift cycle 3 of a 20-bit SLL; last delivered result was 7
    alu_ctrl = 3'b100; arith = 1'b0; op_a = 32'h1; op_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_shift_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_shift_in_ready got %b want 1", in_ready); end
    vectors++; if (result !== 32'd7) begin miscompares++; $display("FAIL flush_shift_result got %h want 00000007", result); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen = 1;
      @(posedge clk); #1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_shift_no_valid got %b want 0", seen); end

    // flush in DONE beats out_ready; result register keeps 0x30
    alu_ctrl = 3'b010; op_a = 32'h10; op_b = 32'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_done_out_valid got %b want 0", out_valid); end
    vectors++; if (result !== 32'h30) begin miscompares++; $display("FAIL flush_done_result got %h want 00000030", result); end

    // flush in IDLE drops the offered op
    alu_ctrl = 3'b000; op_a = 32'h1; op_b = 32'h1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_idle got busy=%b out_valid=%b want 0/0", busy, out_valid); end
    vectors++; if (result !== 32'h30) begin miscompares++; $display("FAIL flush_idle_result got %h want 00000030", result); end
  endtask

  task automatic test_reset_mid_shift;
    bit seen;
    alu_ctrl = 3'b101; arith = 1'b1; op_a = 32'h8000_0000; op_b = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid busy=%b out_valid=%b want 0/0", busy, out_valid); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL rst_mid_result got %h want 00000000", result); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1;
      @(posedge clk); #1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_valid got %b want 0", seen); end
  endtask

  initial begin
    in_valid = 1'b0; alu_ctrl = 3'b000; arith = 1'b0; op_a = '0; op_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_logic_ops();
    test_default_add();
    test_shifts();
    test_back_to_back();
    test_flush();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
